// File: rtl/alu_uart_if_if.sv
// rtl/alu_uart_if_if.sv - UART and ALU side signals of the alu_uart_if bridge
interface alu_uart_if_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_alu_carry;
    logic               i_alu_zero;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;

    // Bridge side
    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_carry, i_alu_zero,
        output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy
    );

    // UART / ALU side
    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_carry, i_alu_zero,
        input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy
    );
endinterface

// File: rtl/alu_uart_if.sv
// rtl/alu_uart_if.sv - UART frame (A, B, op) to ALU bridge; ALU_UART_FLAGS_EN adds a flags byte
module alu_uart_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_uart_if_if.master  bus
);
    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND_RES,
        WAIT_RES
`ifdef ALU_UART_FLAGS_EN
        ,
        SEND_FLG,
        WAIT_FLG
`endif
    } state_t;

    state_t state;
    state_t state_n;

`ifdef ALU_UART_FLAGS_EN
    logic carry_q;
    logic zero_q;
`else
    logic unused_flags;
    assign unused_flags = bus.i_alu_carry ^ bus.i_alu_zero;
`endif

    // State register; rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= WAIT_A;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; rx bytes outside the WAIT_A/B/OP states and tx_done outside WAIT_* are dropped
    always_comb begin
        state_n = state;
        case (state)
            WAIT_A:   if (bus.i_rx_done) state_n = WAIT_B;
            WAIT_B:   if (bus.i_rx_done) state_n = WAIT_OP;
            WAIT_OP:  if (bus.i_rx_done) state_n = EXEC;
            EXEC:     state_n = SEND_RES;
            SEND_RES: state_n = WAIT_RES;
`ifdef ALU_UART_FLAGS_EN
            WAIT_RES: if (bus.i_tx_done) state_n = SEND_FLG;
            SEND_FLG: state_n = WAIT_FLG;
            WAIT_FLG: if (bus.i_tx_done) state_n = WAIT_A;
`else
            WAIT_RES: if (bus.i_tx_done) state_n = WAIT_A;
`endif
            default:  state_n = WAIT_A;
        endcase
    end

    // Operand/opcode capture, ALU result capture and transmit byte selection
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus.o_data_a  <= '0;
            bus.o_data_b  <= '0;
            bus.o_op      <= '0;
            bus.o_tx_data <= '0;
`ifdef ALU_UART_FLAGS_EN
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
`endif
        end else begin
            case (state)
                WAIT_A:  if (bus.i_rx_done) bus.o_data_a <= bus.i_rx_data;
                WAIT_B:  if (bus.i_rx_done) bus.o_data_b <= bus.i_rx_data;
                WAIT_OP: if (bus.i_rx_done) bus.o_op     <= bus.i_rx_data[NB_OP-1:0];
                EXEC: begin
                    bus.o_tx_data <= bus.i_alu_result;
`ifdef ALU_UART_FLAGS_EN
                    carry_q       <= bus.i_alu_carry;
                    zero_q        <= bus.i_alu_zero;
`endif
                end
`ifdef ALU_UART_FLAGS_EN
                WAIT_RES: if (bus.i_tx_done) bus.o_tx_data <= {{(NB_DATA-2){1'b0}}, carry_q, zero_q};
`endif
                default: ;
            endcase
        end
    end

    // Start pulse and busy are pure state decodes so reset leaves no residual pulse
    always_comb begin
        bus.o_tx_start = (state == SEND_RES);
`ifdef ALU_UART_FLAGS_EN
        if (state == SEND_FLG) bus.o_tx_start = 1'b1;
`endif
        bus.o_busy = !((state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP));
    end
endmodule

// File: tb/tb_alu_uart_if.sv
// tb/tb_alu_uart_if.sv - randomized directed bench for alu_uart_if with a frame-level reference
module tb_alu_uart_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_uart_if_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    alu_uart_if #(.NB_DATA(8), .NB_OP(6)) dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {overflow, zero, result}
    function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [7:0] r;
        logic       ov;
        ov = 1'b0;
        case (op)
            6'h20: begin r = a + b; ov = (a[7] == b[7]) && (r[7] != a[7]); end
            6'h22: begin r = a - b; ov = (a[7] != b[7]) && (r[7] != a[7]); end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h02: r = a >> 1;
            6'h03: r = {a[7], a[7:1]};
            default: r = a;
        endcase
        return {ov, (r == 8'h00), r};
    endfunction

    // Combinational ALU driven by the bridge's registered operands
    logic [9:0] alu_out;
    always_comb begin
        alu_out = alu_ref(bus.o_data_a, bus.o_data_b, bus.o_op);
        bus.i_alu_result = alu_out[7:0];
        bus.i_alu_zero   = alu_out[8];
        bus.i_alu_carry  = alu_out[9];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = $urandom_range(0, 255);
    endtask

    task automatic pulse_tx_done();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"},     bus.o_data_a, 0);
        chk({tag, "_b"},     bus.o_data_b, 0);
        chk({tag, "_op"},    bus.o_op, 0);
        chk({tag, "_txd"},   bus.o_tx_data, 0);
        chk({tag, "_start"}, bus.o_tx_start, 0);
        chk({tag, "_busy"},  bus.o_busy, 0);
    endtask

    // One complete frame; optional junk rx bytes while waiting, tx_done during WAIT_B and SEND_RES, and rx+tx together
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input bit junk, input bit stray_tx, input bit dual);
        logic [9:0] exp;
        int         n;
        exp = alu_ref(a, b, opb[5:0]);
        idle($urandom_range(0, 2));
        send(a);
        chk("data_a", bus.o_data_a, a);
        chk("busy_wait_b", bus.o_busy, 0);
        if (stray_tx) begin
            pulse_tx_done();
            chk("stray_tx_start", bus.o_tx_start, 0);
        end
        idle($urandom_range(0, 2));
        send(b);
        chk("data_b", bus.o_data_b, b);
        idle($urandom_range(0, 2));
        send(opb);
        chk("op", bus.o_op, opb[5:0]);
        chk("busy_exec", bus.o_busy, 1);
        chk("start_exec", bus.o_tx_start, 0);
        tick();
        chk("start_lat2", bus.o_tx_start, 1);
        chk("tx_result", bus.o_tx_data, exp[7:0]);
        if (stray_tx) bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        chk("start_one_cycle", bus.o_tx_start, 0);
        chk("busy_wait_res", bus.o_busy, 1);
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            if (junk) begin
                send(8'h55);
            end else begin
                tick();
            end
            chk("wait_res_start", bus.o_tx_start, 0);
            chk("wait_res_txd", bus.o_tx_data, exp[7:0]);
        end
        if (dual) begin
            bus.i_rx_data = 8'hC3;
            bus.i_rx_done = 1'b1;
        end
        pulse_tx_done();
        bus.i_rx_done = 1'b0;
`ifdef ALU_UART_FLAGS_EN
        chk("flg_start", bus.o_tx_start, 1);
        chk("flg_byte", bus.o_tx_data, {6'b0, exp[9], exp[8]});
        tick();
        chk("flg_one_cycle", bus.o_tx_start, 0);
        chk("busy_wait_flg", bus.o_busy, 1);
        idle($urandom_range(0, 2));
        chk("busy_wait_flg2", bus.o_busy, 1);
        pulse_tx_done();
`endif
        chk("busy_done", bus.o_busy, 0);
        chk("start_done", bus.o_tx_start, 0);
        chk("hold_a", bus.o_data_a, a);
        chk("hold_b", bus.o_data_b, b);
        chk("hold_op", bus.o_op, opb[5:0]);
    endtask

    // Reset at a chosen point: 0 after byte A, 1 in EXEC, 2 in WAIT_RES
    task automatic reset_mid(input int stage);
        send(8'hAA);
        chk("rst_pre_a", bus.o_data_a, 8'hAA);
        if (stage > 0) begin
            send(8'h11);
            send(8'h20);
        end
        if (stage > 1) idle(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_mid");
        for (int i = 0; i < 4; i++) begin
            chk("rst_no_pulse", bus.o_tx_start, 0);
            chk("rst_idle_busy", bus.o_busy, 0);
            tick();
        end
    endtask

    initial begin
        logic [7:0] ops [8];
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        rst = 1'b1;
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk_zero("post_reset");

        run_frame(8'h01, 8'h02, 8'h20, 0, 0, 0);
        run_frame(8'h05, 8'h03, 8'h22, 0, 0, 0);
        run_frame(8'h33, 8'h0F, 8'hE4, 0, 0, 0);
        run_frame(8'h7F, 8'h01, 8'h20, 1, 0, 0);
        run_frame(8'h0F, 8'h03, 8'h24, 0, 0, 0);
        run_frame(8'h80, 8'h80, 8'h20, 0, 1, 1);

        reset_mid(0);
        run_frame(8'h12, 8'h34, 8'h26, 0, 0, 0);
        reset_mid(1);
        run_frame(8'hF0, 8'h0F, 8'h25, 0, 0, 0);
        reset_mid(2);
        run_frame(8'h0F, 8'h03, 8'h24, 0, 0, 0);

        for (int k = 0; k < 24; k++) begin
            run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)][5:0]},
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_uart_if.md
ALU_UART_IF -- requirements
Module: alu_uart_if

Interface
REQ-001 Parameter NB_DATA, default 8, width of operands, result and UART bytes.
REQ-002 Parameter NB_OP, default 6, width of ALU operation code.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-high (1 = reset) despite the name.
REQ-005 i_rx_data  input  NB_DATA  byte from UART receiver, valid when i_rx_done=1.
REQ-006 i_rx_done  input  1  one-cycle pulse: received byte valid.
REQ-007 i_tx_done  input  1  one-cycle pulse: UART transmitter finished current byte.
REQ-008 i_alu_result  input  NB_DATA  combinational ALU result.
REQ-009 i_alu_carry  input  1  ALU carry/overflow flag.
REQ-010 i_alu_zero  input  1  ALU zero flag.
REQ-011 o_data_a  output  NB_DATA  registered operand A to ALU.
REQ-012 o_data_b  output  NB_DATA  registered operand B to ALU.
REQ-013 o_op  output  NB_OP  registered operation code to ALU.
REQ-014 o_tx_data  output  NB_DATA  byte to UART transmitter, stable from o_tx_start until i_tx_done.
REQ-015 o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-016 o_busy  output  1  high in EXEC and all transmit states.

Function
REQ-017 FSM states SHALL be: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-018 WAIT_A + i_rx_done: o_data_a <= i_rx_data at that edge, next state WAIT_B.
REQ-019 WAIT_B + i_rx_done: o_data_b <= i_rx_data, next WAIT_OP.
REQ-020 WAIT_OP + i_rx_done: o_op <= i_rx_data[NB_OP-1:0] (upper bits discarded), next EXEC.
REQ-021 EXEC lasts exactly one cycle (ALU settle); at its exit edge result, carry, zero are captured into internal registers, o_tx_data <= captured result, next SEND_RES.
REQ-022 SEND_RES: o_tx_start=1 for exactly this one cycle, next WAIT_RES unconditionally.
REQ-023 WAIT_RES: hold until i_tx_done; then SEND_FLG if flags enabled (REQ-031) else WAIT_A.
REQ-024 SEND_FLG: o_tx_data = {zeros, carry_q, zero_q} (bit1 carry, bit0 zero), o_tx_start=1 one cycle, next WAIT_FLG; WAIT_FLG + i_tx_done -> WAIT_A.
REQ-025 Latency: op byte i_rx_done edge to o_tx_start high = 2 cycles.
REQ-026 i_rx_done in EXEC/SEND/WAIT states SHALL be ignored (byte dropped, no register change).
REQ-027 i_tx_done outside WAIT_RES/WAIT_FLG SHALL be ignored.
REQ-028 o_data_a, o_data_b, o_op SHALL hold their values until overwritten by a new frame.
REQ-029 i_rx_done and i_tx_done asserted together in WAIT_RES: tx_done acted on, rx byte dropped.

Reset
REQ-030 rst_n=1 at a clock edge, in any state including mid-frame or mid-transmission: state WAIT_A, all outputs and internal captures 0, o_tx_start 0 with no residual pulse; takes priority over all inputs.

Configuration
REQ-031 Macro ALU_UART_FLAGS_EN: defined -> SEND_FLG/WAIT_FLG present, two bytes per frame (result, flags); undefined -> those states not compiled, one byte per frame, WAIT_RES + i_tx_done -> WAIT_A, carry/zero inputs unused.

Verification
REQ-032 Bytes 0x01,0x02,0x20 -> o_data_a=0x01, o_data_b=0x02, o_op=0x20; ALU 0x03 -> o_tx_start 2 cycles after op byte, o_tx_data=0x03.
REQ-033 FLAGS_EN, bytes 0x7F,0x01,0x20, ALU 0x80 carry=1 zero=0 -> tx 0x80 then after i_tx_done tx 0x02; returns WAIT_A after second i_tx_done.
REQ-034 Op byte 0xE4 -> o_op=0x24 (upper bits dropped).
REQ-035 Extra byte 0x55 during WAIT_RES -> no register change; next frame 0x0F,0x03,0x24 processed normally.
REQ-036 rst_n=1 for one cycle after byte A=0xAA and during WAIT_RES -> all outputs 0, o_tx_start never pulses, next frame starts at A.
REQ-037 Without FLAGS_EN, frame 0x05,0x03,0x22 -> exactly one o_tx_start pulse, o_tx_data=0x02.
